// File: rtl/ddr3_bist_pkg.sv
// ddr3_bist_pkg: shared FSM state encoding and default data-pattern seed
package ddr3_bist_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_GAP = 3'd2,
        RD_REQ = 3'd3,
        RD_GAP = 3'd4,
        DONE   = 3'd5
    } state_t;
    localparam logic [31:0] DEFAULT_SEED = 32'hA5A5_5A5A;
endpackage

// File: rtl/ddr3_bist_pattern_gen.sv
// bist_pattern_gen: expected data word for a byte address (address XOR seed)
// Ports: addr (byte address in), word (32-bit pattern out)
module bist_pattern_gen
    import ddr3_bist_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter logic [31:0] SEED   = DEFAULT_SEED
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       word
);
    assign word = 32'(addr) ^ SEED;
endmodule

// File: rtl/ddr3_bist.sv
// ddr3_bist: write-then-read-back memory self test over a word-aligned range
// Ports: clk, rst (async, active-high); start/base/len test request;
//        addr_o/data_o/we_o/rd_o/data_i/ack_i memory bus;
//        busy/done/pass/err_count/err_addr status.
// Optional: define BIST_TIMEOUT_EN to abort a request after TIMEOUT cycles without ack_i.
module ddr3_bist
    import ddr3_bist_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          LEN_W   = 20,
    parameter logic [31:0] SEED    = DEFAULT_SEED,
    parameter int          TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       data_o,
    input  logic [31:0]       data_i,
    output logic              we_o,
    output logic              rd_o,
    input  logic              ack_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] err_addr
);
    state_t            state, next;
    logic [ADDR_W-1:0] base_r, cur_addr;
    logic [LEN_W-1:0]  len_r, idx;
    logic [31:0]       pat;
    logic              accept, last, is_req, tmo, timed_out;

    assign cur_addr = base_r + ADDR_W'({idx, 2'b00});
    assign last     = idx == len_r - LEN_W'(1);
    assign is_req   = state == WR_REQ || state == RD_REQ;
    assign accept   = start && (state == IDLE || state == DONE);

    bist_pattern_gen #(.ADDR_W(ADDR_W), .SEED(SEED)) u_pat (.addr(cur_addr), .word(pat));

`ifdef BIST_TIMEOUT_EN
    logic [$clog2(TIMEOUT+1)-1:0] tmo_cnt;
    // Outside REQ states the counter sits at zero, so each REQ entry starts fresh.
    assign tmo = is_req && !ack_i && tmo_cnt == ($clog2(TIMEOUT+1))'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
        end else begin
            tmo_cnt   <= is_req && !ack_i && !tmo ? tmo_cnt + 1'b1 : '0;
            timed_out <= accept ? 1'b0 : (timed_out || tmo);
        end
`else
    assign tmo       = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = start ? (len == '0 ? DONE : WR_REQ) : state;
            WR_REQ:     next = tmo ? DONE : (ack_i ? WR_GAP : WR_REQ);
            WR_GAP:     next = last ? RD_REQ : WR_REQ;
            RD_REQ:     next = tmo ? DONE : (ack_i ? RD_GAP : RD_REQ);
            RD_GAP:     next = last ? DONE : RD_REQ;
            default:    next = IDLE;
        endcase
    end

    // Bus outputs derive from the state register so reset clears them at once.
    assign we_o   = state == WR_REQ;
    assign rd_o   = state == RD_REQ;
    assign addr_o = is_req ? cur_addr : '0;
    assign data_o = we_o ? pat : '0;
    assign busy   = state inside {WR_REQ, WR_GAP, RD_REQ, RD_GAP};
    assign done   = state == DONE;
    assign pass   = done && err_count == '0 && !timed_out;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            base_r    <= '0;
            len_r     <= '0;
            idx       <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else if (accept) begin
            base_r    <= base & ~ADDR_W'(3);
            len_r     <= len;
            idx       <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            if (state == WR_GAP || state == RD_GAP)
                idx <= last ? '0 : idx + LEN_W'(1);
            if (rd_o && ack_i && data_i != pat) begin
                err_count <= err_count == 16'hFFFF ? err_count : err_count + 16'd1;
                if (err_count == '0) err_addr <= cur_addr;
            end
        end
endmodule
